reflet_ram8_word_ctrl: RTL and testbench

- Upstream sequencer between the CPU data port and the byte-wide RAM block (reflet_ram8).
- Accepts one word or byte access per request and splits it into consecutive byte accesses, little-endian.
- Accounts for the RAM's one-cycle registered read latency.
- Returns the assembled word with a one-cycle ready pulse.

---
 rtl/reflet_mem_pkg.sv | 18 +
 rtl/reflet_ram8_word_ctrl.sv | 106 ++++++++++
 tb/tb_reflet_ram8_word_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reflet_mem_pkg.sv
// Shared definitions for the reflet byte-wide memory path: byte width,
// word-controller state encoding and the bytes-per-word helper.
package reflet_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic int bytes_per_word(input int ws);
    return ws / BYTE_W;
  endfunction

endpackage

// File: rtl/reflet_ram8_word_ctrl.sv
// Splits one CPU word/byte access into consecutive little-endian byte accesses
// on the byte-wide RAM, absorbing its one-cycle registered read latency.
module reflet_ram8_word_ctrl
  import reflet_mem_pkg::*;
#(
  parameter int wordsize = 16,
  parameter int addrSize = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                write_en,
  input  logic                byte_mode,
  input  logic [addrSize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] data_out,
  output logic                ready,
  output logic                busy,
  output logic                ram_enable,
  output logic                ram_write_en,
  output logic [addrSize-1:0] ram_addr,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata
);

  localparam int NB = bytes_per_word(wordsize);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [addrSize-1:0] r_addr;
  logic [wordsize-1:0] r_data;
  logic                r_we;
  logic                r_byte;
  logic [CNT_W-1:0]    w_last;

  function automatic logic [BYTE_W-1:0] lane_get(input logic [wordsize-1:0] w,
                                                 input logic [CNT_W-1:0]    k);
    logic [BYTE_W-1:0] b;
    b = '0;
    for (int i = 0; i < NB; i++)
      if (k == CNT_W'(i)) b = w[i*BYTE_W +: BYTE_W];
    return b;
  endfunction

  // Lane 0 is always captured first, so writing it clears the other lanes;
  // this is what leaves the upper bits zero after a byte read.
  function automatic logic [wordsize-1:0] lane_put(input logic [wordsize-1:0] w,
                                                   input logic [CNT_W-1:0]    k,
                                                   input logic [BYTE_W-1:0]   b);
    logic [wordsize-1:0] r;
    r = (k == '0) ? '0 : w;
    for (int i = 0; i < NB; i++)
      if (k == CNT_W'(i)) r[i*BYTE_W +: BYTE_W] = b;
    return r;
  endfunction

  assign w_last = r_byte ? '0 : CNT_W'(NB - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_byte   <= 1'b0;
      data_out <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_data  <= data_in;
            r_we    <= write_en;
            r_byte  <= byte_mode;
            r_cnt   <= '0;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Byte cnt-1 was issued last cycle and is on ram_rdata now.
          if (!r_we && r_cnt != '0)
            data_out <= lane_put(data_out, r_cnt - 1'b1, ram_rdata);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_we) data_out <= lane_put(data_out, w_last, ram_rdata);
          ready   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM side is decoded from state so it collapses as soon as reset asserts.
  assign busy         = (r_state == ST_ACCESS) || (r_state == ST_DRAIN);
  assign ram_enable   = (r_state == ST_ACCESS);
  assign ram_write_en = ram_enable & r_we;
  assign ram_addr     = ram_enable ? r_addr + addrSize'(r_cnt) : '0;
  assign ram_wdata    = ram_enable ? lane_get(r_data, r_cnt) : '0;

endmodule

// File: tb/tb_reflet_ram8_word_ctrl.sv
// Directed bench for reflet_ram8_word_ctrl (16-bit word, 7-bit address) with a
// behavioural 128-byte registered-read RAM attached to the RAM port.
module tb_reflet_ram8_word_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        write_en = 1'b0;
  logic        byte_mode = 1'b0;
  logic [6:0]  addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        ready, busy;
  logic        ram_enable, ram_write_en;
  logic [6:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  logic [7:0]  mem [128];
  int          nVec = 0;
  int          nMiss = 0;

  always #5 clk = ~clk;

  reflet_ram8_word_ctrl #(.wordsize(16), .addrSize(7)) dut (
    .clk(clk), .reset(reset), .req(req), .write_en(write_en),
    .byte_mode(byte_mode), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .busy(busy),
    .ram_enable(ram_enable), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Byte RAM: registered read, write on enable; every byte starts at i ^ 0xA5.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge clk);
      if (ram_enable) begin
        ram_rdata <= mem[ram_addr];
        if (ram_write_en) mem[ram_addr] = ram_wdata;
      end
    end
  end

  // lat counts negedges after the request negedge; ready lands at N+2.
  task automatic run_access(input logic we, input logic bm, input logic [6:0] a,
                            input logic [15:0] d, output int lat, output int busyCnt,
                            output int weCnt, output logic [15:0] dout);
    @(negedge clk);
    req = 1'b1; write_en = we; byte_mode = bm; addr = a; data_in = d;
    lat = 0; busyCnt = 0; weCnt = 0; dout = 'x;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (busy) busyCnt++;
      if (ram_write_en) weCnt++;
      if (ready) begin lat = i; dout = data_out; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nVec++; if (data_out !== 16'h0) begin nMiss++; $display("[TB] FAIL rst_dout got %h want 0000", data_out); end
    nVec++; if ({ready, busy, ram_enable, ram_write_en} !== 4'b0) begin nMiss++; $display("[TB] FAIL rst_flags got %b want 0000", {ready, busy, ram_enable, ram_write_en}); end
    nVec++; if ({ram_addr, ram_wdata} !== 15'h0) begin nMiss++; $display("[TB] FAIL rst_ramaddr_wdata got %h/%h want 00/00", ram_addr, ram_wdata); end
    reset = 1'b1;
  endtask

  task automatic test_word_write();
    int lat, bc, wc; logic [15:0] d;
    run_access(1'b1, 1'b0, 7'h10, 16'hBEEF, lat, bc, wc, d);
    nVec++; if (lat !== 4) begin nMiss++; $display("[TB] FAIL wr_lat got %0d want 4", lat); end
    nVec++; if (bc !== 3) begin nMiss++; $display("[TB] FAIL wr_busy got %0d want 3", bc); end
    nVec++; if ({mem[7'h11], mem[7'h10]} !== 16'hBEEF) begin nMiss++; $display("[TB] FAIL wr_mem got %h want beef", {mem[7'h11], mem[7'h10]}); end
    nVec++; if (d !== 16'h0) begin nMiss++; $display("[TB] FAIL wr_dout_hold got %h want 0000", d); end
    @(negedge clk);
    nVec++; if (ready !== 1'b0) begin nMiss++; $display("[TB] FAIL wr_ready_width got %b want 0", ready); end
  endtask

  task automatic test_word_read();
    int lat, bc, wc; logic [15:0] d;
    run_access(1'b0, 1'b0, 7'h10, 16'h0000, lat, bc, wc, d);
    nVec++; if (lat !== 4) begin nMiss++; $display("[TB] FAIL rd_lat got %0d want 4", lat); end
    nVec++; if (d !== 16'hBEEF) begin nMiss++; $display("[TB] FAIL rd_data got %h want beef", d); end
    nVec++; if (wc !== 0) begin nMiss++; $display("[TB] FAIL rd_we_seen got %0d want 0", wc); end
  endtask

  task automatic test_byte_mode();
    int lat, bc, wc; logic [15:0] d;
    run_access(1'b0, 1'b1, 7'h11, 16'h0000, lat, bc, wc, d);
    nVec++; if (lat !== 3) begin nMiss++; $display("[TB] FAIL brd_lat got %0d want 3", lat); end
    nVec++; if (bc !== 2) begin nMiss++; $display("[TB] FAIL brd_busy got %0d want 2", bc); end
    nVec++; if (d !== 16'h00BE) begin nMiss++; $display("[TB] FAIL brd_data got %h want 00be", d); end
    run_access(1'b1, 1'b1, 7'h12, 16'hFF5A, lat, bc, wc, d);
    nVec++; if (lat !== 3) begin nMiss++; $display("[TB] FAIL bwr_lat got %0d want 3", lat); end
    nVec++; if ({mem[7'h13], mem[7'h12], mem[7'h11]} !== 24'hB65ABE) begin nMiss++; $display("[TB] FAIL bwr_mem got %h want b65abe", {mem[7'h13], mem[7'h12], mem[7'h11]}); end
    nVec++; if (d !== 16'h00BE) begin nMiss++; $display("[TB] FAIL bwr_dout_hold got %h want 00be", d); end
  endtask

  task automatic test_wrap();
    int lat, bc, wc; logic [15:0] d;
    run_access(1'b1, 1'b0, 7'h7F, 16'h1234, lat, bc, wc, d);
    nVec++; if ({mem[7'h00], mem[7'h7F]} !== 16'h1234) begin nMiss++; $display("[TB] FAIL wrap_mem got %h want 1234", {mem[7'h00], mem[7'h7F]}); end
    run_access(1'b0, 1'b0, 7'h7F, 16'h0000, lat, bc, wc, d);
    nVec++; if (d !== 16'h1234) begin nMiss++; $display("[TB] FAIL wrap_rd got %h want 1234", d); end
  endtask

  // req held high: second read accepted at the edge closing the first ready cycle.
  task automatic test_back_to_back();
    int r1, r2; logic [15:0] d1, d2, dHold;
    r1 = 0; r2 = 0; d1 = 'x; d2 = 'x; dHold = 'x;
    @(negedge clk);
    req = 1'b1; write_en = 1'b0; byte_mode = 1'b0; addr = 7'h10;
    for (int i = 1; i <= 20 && r2 == 0; i++) begin
      @(negedge clk);
      if (i == r1 + 1 && r1 != 0) dHold = data_out;
      if (ready) begin
        if (r1 == 0) begin r1 = i; d1 = data_out; addr = 7'h7F; end
        else begin r2 = i; d2 = data_out; end
      end
    end
    req = 1'b0;
    nVec++; if (r1 !== 4 || r2 !== 8) begin nMiss++; $display("[TB] FAIL b2b_ready_at got %0d,%0d want 4,8", r1, r2); end
    nVec++; if (d1 !== 16'hBEEF || d2 !== 16'h1234) begin nMiss++; $display("[TB] FAIL b2b_data got %h,%h want beef,1234", d1, d2); end
    nVec++; if (dHold !== 16'hBEEF) begin nMiss++; $display("[TB] FAIL b2b_dout_hold got %h want beef", dHold); end
    @(negedge clk);
    nVec++; if (busy !== 1'b0 || ram_enable !== 1'b0) begin nMiss++; $display("[TB] FAIL b2b_idle got busy=%b en=%b want 0,0", busy, ram_enable); end
  endtask

  task automatic test_req_while_busy();
    int rdy, enCnt; logic [15:0] d;
    rdy = 0; enCnt = 0; d = 'x;
    @(negedge clk);
    req = 1'b1; write_en = 1'b0; byte_mode = 1'b0; addr = 7'h10; data_in = 16'h0000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req = (i == 1 || i == 2);
      write_en = 1'b1; addr = 7'h40; data_in = 16'h7777;
      if (ram_enable) enCnt++;
      if (ready && rdy == 0) begin rdy = i; d = data_out; end
    end
    req = 1'b0;
    nVec++; if (rdy !== 4 || d !== 16'hBEEF) begin nMiss++; $display("[TB] FAIL busyreq_rd got %0d/%h want 4/beef", rdy, d); end
    nVec++; if (enCnt !== 2) begin nMiss++; $display("[TB] FAIL busyreq_accesses got %0d want 2", enCnt); end
    nVec++; if ({mem[7'h41], mem[7'h40]} !== 16'hE4E5) begin nMiss++; $display("[TB] FAIL busyreq_mem40 got %h want e4e5", {mem[7'h41], mem[7'h40]}); end
  endtask

  task automatic test_reset_midaccess();
    int lat, bc, wc; logic [15:0] d; int rdyCnt;
    rdyCnt = 0;
    @(negedge clk);
    req = 1'b1; write_en = 1'b1; byte_mode = 1'b0; addr = 7'h20; data_in = 16'hAAAA;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    nVec++; if (ram_enable !== 1'b1 || ram_addr !== 7'h21) begin nMiss++; $display("[TB] FAIL mid_k1 got en=%b addr=%h want 1/21", ram_enable, ram_addr); end
    reset = 1'b0;
    #1;
    nVec++; if ({ram_enable, ram_write_en, busy, ready} !== 4'b0) begin nMiss++; $display("[TB] FAIL mid_async_drop got %b want 0000", {ram_enable, ram_write_en, busy, ready}); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ready) rdyCnt++; end
    nVec++; if (rdyCnt !== 0) begin nMiss++; $display("[TB] FAIL mid_no_ready got %0d want 0", rdyCnt); end
    nVec++; if ({mem[7'h21], mem[7'h20]} !== 16'h84AA) begin nMiss++; $display("[TB] FAIL mid_mem got %h want 84aa", {mem[7'h21], mem[7'h20]}); end
    run_access(1'b0, 1'b0, 7'h20, 16'h0000, lat, bc, wc, d);
    nVec++; if (lat !== 4 || d !== 16'h84AA) begin nMiss++; $display("[TB] FAIL mid_fresh got %0d/%h want 4/84aa", lat, d); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_mode();
    test_wrap();
    test_back_to_back();
    test_req_while_busy();
    test_reset_midaccess();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
